// File: rtl/fixed_mac.sv
// Pipelined signed fixed-point multiply-accumulate: multiply stage, accumulate stage,
// then a rounded/saturated result register with valid/ready handshakes on both sides.
module fixed_mac #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int ACC_GUARD = 8,
    parameter int ROUND     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_sat
);
    localparam int PW   = 2 * WIDTH;
    localparam int ACCW = PW + ACC_GUARD;

    localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACCW-1:0] RND_C =
        (ROUND != 0) ? ({{(ACCW-1){1'b0}}, 1'b1} << (FRAC-1)) : '0;

    logic                   s1_valid;
    logic                   s1_first;
    logic                   s1_last;
    logic signed [PW-1:0]   s1_prod;
    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   b_ext;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] rnd;
    logic signed [ACCW-1:0] shifted;
    logic                   advance;
    logic                   accept;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [WIDTH-1:0]       res_next;

    assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
    assign b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};
    assign prod  = a_ext * b_ext;

    // Only a last beat can be blocked by a full, undrained output register.
    assign advance  = s1_valid && (!s1_last || !out_valid || out_ready);
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_next = (s1_first ? '0 : acc) + {{ACC_GUARD{s1_prod[PW-1]}}, s1_prod};
        rnd      = acc_next + RND_C;
        shifted  = rnd >>> FRAC;
        sat_hi   = shifted > MAX_V;
        sat_lo   = shifted < MIN_V;
        res_next = shifted[WIDTH-1:0];
        if (sat_hi) begin
            res_next = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            res_next = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_prod  <= prod;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (advance) begin
            acc <= acc_next;
        end
    end

    // Reload and drain may coincide; the reload wins and out_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sat    <= 1'b0;
        end else if (advance && s1_last) begin
            out_valid  <= 1'b1;
            out_result <= res_next;
            out_sat    <= sat_hi | sat_lo;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fixed_mac.sv
// Scoreboard bench for fixed_mac: a truncating and a rounding instance share stimulus,
// expected results come from an integer model and are queued at beat acceptance.
module tb_fixed_mac;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready0, in_ready1, ov0, ov1, sat0, sat1;
    logic [15:0] res0, res1;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_out = 0;
    int          n_before;
    bit          rand_rdy = 1'b0;
    longint      acc_m = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] e0, e1;

    always #5 clk = ~clk;

    fixed_mac #(.WIDTH(16), .FRAC(8), .ACC_GUARD(8), .ROUND(0)) u_r0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_result(res0), .out_sat(sat0));

    fixed_mac #(.WIDTH(16), .FRAC(8), .ACC_GUARD(8), .ROUND(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_result(res1), .out_sat(sat1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [16:0] model_res(input longint sum, input bit rnd);
        longint r;
        longint sh;
        r  = sum + (rnd ? 64'sd128 : 64'sd0);
        sh = r >>> 8;
        if (sh > 32767) return {1'b1, 16'h7FFF};
        if (sh < -32768) return {1'b1, 16'h8000};
        return {1'b0, sh[15:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit first, input bit last);
        bit rdy;
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_first = first;
        in_last = last;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready0;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        chk("accept_timeout", ok, 1);
        if (ok) begin
            if (first) acc_m = 0;
            acc_m += longint'($signed(a)) * longint'($signed(b));
            if (last) begin
                q0.push_back(model_res(acc_m, 1'b0));
                q1.push_back(model_res(acc_m, 1'b1));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) wait_cycles(1);
        chk("drain_r0", q0.size(), 0);
        chk("drain_r1", q1.size(), 0);
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #2;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov0 && out_ready) begin
                n_out++;
                chk("r0_pending", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    chk("r0_result", {15'b0, sat0, res0}, {15'b0, e0});
                end
            end
            if (ov1 && out_ready) begin
                chk("r1_pending", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("r1_result", {15'b0, sat1, res1}, {15'b0, e1});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_valid", ov0, 0);
        chk("rst_result", res0, 0);
        chk("rst_sat", sat0, 0);
        chk("rst_ready", in_ready0, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(1);
        out_ready = 1'b1;

        // single multiply and latency
        send(16'h0200, 16'h0300, 1, 1);
        chk("lat_edge0", ov0, 0);
        @(negedge clk);
        chk("lat_cycle1", ov0, 0);
        wait_cycles(1);
        chk("lat_cycle2", ov0, 1);
        chk("single_res", res0, 16'h0600);
        wait_cycles(3);

        // dot product
        n_before = n_out;
        send(16'h0180, 16'h0200, 1, 0);
        chk("dot_quiet0", ov0, 0);
        send(16'h0200, 16'h0080, 0, 0);
        chk("dot_quiet1", ov0, 0);
        send(16'hFF00, 16'h0200, 0, 1);
        wait_cycles(4);
        chk("dot_count", n_out - n_before, 1);
        chk("dot_res", res0, 16'h0200);

        // rounding
        send(16'h001A, 16'h001A, 1, 1);
        send(16'hFFE6, 16'h001A, 1, 1);
        wait_cycles(4);

        // saturation
        send(16'h6400, 16'h6400, 1, 1);
        send(16'h9C00, 16'h6400, 1, 1);
        send(16'h0100, 16'h0100, 1, 1);
        wait_cycles(4);
        drain();

        // backpressure
        out_ready = 1'b0;
        send(16'h0200, 16'h0300, 1, 1);
        send(16'h0180, 16'h0200, 1, 1);
        wait_cycles(3);
        chk("bp_valid", ov0, 1);
        chk("bp_res", res0, 16'h0600);
        chk("bp_ready0", in_ready0, 0);
        chk("bp_ready1", in_ready1, 0);
        wait_cycles(3);
        chk("bp_hold", res0, 16'h0600);
        n_before = n_out;
        out_ready = 1'b1;
        wait_cycles(5);
        chk("bp_count", n_out - n_before, 2);
        drain();

        // running total across runs
        send(16'h0100, 16'h0100, 1, 1);
        send(16'h0100, 16'h0100, 0, 1);
        wait_cycles(4);
        drain();

        // random runs with random output backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
                send(16'($urandom), 16'($urandom), j == 0, j == len - 1);
            if ($urandom_range(0, 3) == 0) wait_cycles(1);
        end
        rand_rdy = 1'b0;
        wait_cycles(1);
        out_ready = 1'b1;
        drain();

        // reset mid-run
        send(16'h0300, 16'h0100, 1, 1);
        wait_cycles(3);
        drain();
        send(16'h0100, 16'h0200, 1, 0);
        send(16'h0300, 16'h0100, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov0, 0);
        chk("mid_rst_result", res0, 0);
        chk("mid_rst_sat", sat0, 0);
        chk("mid_rst_ready", in_ready0, 1);
        q0.delete();
        q1.delete();
        acc_m = 0;
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(1);
        send(16'h0100, 16'h0100, 0, 1);
        wait_cycles(3);
        chk("post_rst_acc", res0, 16'h0100);
        send(16'h0100, 16'h0100, 1, 1);
        wait_cycles(3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
